// File: rtl/mips_alu_pkg.sv
// Shared ALU opcodes and multiplier sequencer state encoding.
// The datapath ALU mux decodes the same constants, so they live here rather
// than inside the multiplier.
package mips_alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b1001;

    localparam logic [2:0] MS_IDLE   = 3'd0;
    localparam logic [2:0] MS_NEG_A  = 3'd1;
    localparam logic [2:0] MS_NEG_B  = 3'd2;
    localparam logic [2:0] MS_ITER   = 3'd3;
    localparam logic [2:0] MS_NEG_LO = 3'd4;
    localparam logic [2:0] MS_NEG_HI = 3'd5;
    localparam logic [2:0] MS_INC_HI = 3'd6;
    localparam logic [2:0] MS_DONE   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = MS_IDLE,
        ST_NEG_A  = MS_NEG_A,
        ST_NEG_B  = MS_NEG_B,
        ST_ITER   = MS_ITER,
        ST_NEG_LO = MS_NEG_LO,
        ST_NEG_HI = MS_NEG_HI,
        ST_INC_HI = MS_INC_HI,
        ST_DONE   = MS_DONE
    } mult_state_t;

endpackage

// File: rtl/mult_seq_mips_if.sv
// Request/result bus of the multiplier plus its borrowed shared-ALU port.
// master: the pipeline side that issues MULT/MULTU and hosts the ALU.
// slave:  the multiplier sequencer.
interface mult_seq_mips_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_result;

    modport master (
        output start, is_signed, op_a, op_b, alu_result,
        input  busy, done, hi, lo, alu_a, alu_b, alu_ctrl
    );

    modport slave (
        input  start, is_signed, op_a, op_b, alu_result,
        output busy, done, hi, lo, alu_a, alu_b, alu_ctrl
    );
endinterface

// File: rtl/mult_seq_mips.sv
// Multi-cycle 32x32->64 shift-add multiplier for MULT/MULTU.
// Has no adder of its own; every arithmetic step goes through the shared ALU.
// Signed operands are reduced to magnitudes first, and the 64-bit product is
// negated afterwards (lo negate, hi invert, hi += borrow-free flag).
//
// state  | meaning
// IDLE   | waiting for start; alu operands driven to 0
// NEG_A  | a_reg <= -a_reg when negative (signed only)
// NEG_B  | acc_lo (multiplier) <= -acc_lo when negative (signed only)
// ITER   | one shift-add step, WIDTH times
// NEG_LO | acc_lo <= -acc_lo, remember whether acc_lo was zero
// NEG_HI | acc_hi <= ~acc_hi
// INC_HI | acc_hi <= acc_hi + lo_zero, result to hi/lo
// DONE   | done pulse, hi/lo valid
module mult_seq_mips
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset_n,
    mult_seq_mips_if.slave  bus
);

    mult_state_t      state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [CNT_W-1:0] cnt;
    logic             signed_op;
    logic             neg_flag;
    logic             lo_zero;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic [WIDTH-1:0] iter_sum;
    logic             iter_carry;
    logic [WIDTH-1:0] iter_hi;
    logic [WIDTH-1:0] iter_lo;
    logic             last_iter;

    // Shared ALU operand selection, purely from state and registers.
    always_comb begin
        bus.alu_a    = '0;
        bus.alu_b    = '0;
        bus.alu_ctrl = 4'b0000;
        case (state)
            ST_NEG_A: begin
                bus.alu_b    = a_reg;
                bus.alu_ctrl = ALU_SUB;
            end
            ST_NEG_B: begin
                bus.alu_b    = acc_lo;
                bus.alu_ctrl = ALU_SUB;
            end
            ST_ITER: begin
                bus.alu_a    = acc_hi;
                bus.alu_b    = a_reg;
                bus.alu_ctrl = ALU_ADD;
            end
            ST_NEG_LO: begin
                bus.alu_b    = acc_lo;
                bus.alu_ctrl = ALU_SUB;
            end
            ST_NEG_HI: begin
                bus.alu_a    = acc_hi;
                bus.alu_b    = '1;
                bus.alu_ctrl = ALU_XOR;
            end
            ST_INC_HI: begin
                bus.alu_a    = acc_hi;
                bus.alu_b    = {{(WIDTH-1){1'b0}}, lo_zero};
                bus.alu_ctrl = ALU_ADD;
            end
            default: ;
        endcase
    end

    // One shift-add step; the carry out of the add is recovered by an
    // unsigned wrap compare because the shared ALU exposes no carry flag.
    always_comb begin
        iter_sum   = acc_lo[0] ? bus.alu_result : acc_hi;
        iter_carry = acc_lo[0] & (bus.alu_result < acc_hi);
        iter_hi    = {iter_carry, iter_sum[WIDTH-1:1]};
        iter_lo    = {iter_sum[0], acc_lo[WIDTH-1:1]};
        last_iter  = (cnt == CNT_W'(WIDTH - 1));
    end

    // Sequencer FSM with registered busy/done/hi/lo.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            a_reg     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            cnt       <= '0;
            signed_op <= 1'b0;
            neg_flag  <= 1'b0;
            lo_zero   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            hi_r      <= '0;
            lo_r      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_reg     <= bus.op_a;
                        acc_lo    <= bus.op_b;
                        acc_hi    <= '0;
                        cnt       <= '0;
                        signed_op <= bus.is_signed;
                        // Sign of the result comes from the operands as latched,
                        // before either magnitude step touches them.
                        neg_flag  <= bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                        busy_r    <= 1'b1;
                        state     <= bus.is_signed ? ST_NEG_A : ST_ITER;
                    end
                end
                ST_NEG_A: begin
                    if (a_reg[WIDTH-1]) a_reg <= bus.alu_result;
                    state <= ST_NEG_B;
                end
                ST_NEG_B: begin
                    if (acc_lo[WIDTH-1]) acc_lo <= bus.alu_result;
                    state <= ST_ITER;
                end
                ST_ITER: begin
                    acc_hi <= iter_hi;
                    acc_lo <= iter_lo;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        cnt <= '0;
                        if (signed_op) begin
                            state <= ST_NEG_LO;
                        end else begin
                            hi_r   <= iter_hi;
                            lo_r   <= iter_lo;
                            done_r <= 1'b1;
                            state  <= ST_DONE;
                        end
                    end
                end
                ST_NEG_LO: begin
                    lo_zero <= (acc_lo == '0);
                    if (neg_flag) acc_lo <= bus.alu_result;
                    state <= ST_NEG_HI;
                end
                ST_NEG_HI: begin
                    if (neg_flag) acc_hi <= bus.alu_result;
                    state <= ST_INC_HI;
                end
                ST_INC_HI: begin
                    if (neg_flag) begin
                        acc_hi <= bus.alu_result;
                        hi_r   <= bus.alu_result;
                    end else begin
                        hi_r   <= acc_hi;
                    end
                    lo_r   <= acc_lo;
                    done_r <= 1'b1;
                    state  <= ST_DONE;
                end
                ST_DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

endmodule

// File: tb/tb_mult_seq_mips.sv
// Directed bench for mult_seq_mips with a behavioural shared ALU.
module tb_mult_seq_mips;
    import mips_alu_pkg::*;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    mult_seq_mips_if #(.WIDTH(32)) bus ();

    mult_seq_mips #(.WIDTH(32), .CNT_W(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Shared ALU stand-in: combinational, same-cycle result.
    always_comb begin
        case (bus.alu_ctrl)
            4'b0010: bus.alu_result = bus.alu_a + bus.alu_b;
            4'b0110: bus.alu_result = bus.alu_a - bus.alu_b;
            4'b1001: bus.alu_result = bus.alu_a ^ bus.alu_b;
            default: bus.alu_result = 32'h0;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout: sim time limit, observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation at a negedge (cycle 0) and track it to completion.
    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input bit extra_starts);
        int lat;
        int iter_first;
        int done_cnt;
        int done_cyc;
        int busy_bad;
        int ctrl_bad;
        lat        = sgn ? 38 : 33;
        iter_first = sgn ? 3 : 1;
        done_cnt   = 0;
        done_cyc   = -1;
        busy_bad   = 0;
        ctrl_bad   = 0;
        bus.start     = 1'b1;
        bus.is_signed = sgn;
        bus.op_a      = a;
        bus.op_b      = b;
        for (int c = 1; c <= lat + 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
                if (c == lat) begin
                    chk({tag, " hi"}, {32'h0, bus.hi}, {32'h0, exp_hi});
                    chk({tag, " lo"}, {32'h0, bus.lo}, {32'h0, exp_lo});
                end
            end
            if (bus.busy !== ((c >= 1) && (c <= lat))) busy_bad++;
            if ((c >= iter_first) && (c < iter_first + 32) && (bus.alu_ctrl !== ALU_ADD))
                ctrl_bad++;
            bus.start = extra_starts && ((c == 5) || (c == 33));
            bus.op_a  = 32'h1234_5678;
            bus.op_b  = 32'h0000_0003;
        end
        bus.start = 1'b0;
        chk({tag, " done_cycle"}, 64'(done_cyc), 64'(lat));
        chk({tag, " done_count"}, 64'(done_cnt), 64'd1);
        chk({tag, " busy_window_errs"}, 64'(busy_bad), 64'd0);
        chk({tag, " iter_ctrl_errs"}, 64'(ctrl_bad), 64'd0);
        chk({tag, " hi_hold"}, {32'h0, bus.hi}, {32'h0, exp_hi});
        chk({tag, " lo_hold"}, {32'h0, bus.lo}, {32'h0, exp_lo});
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        reset_n       = 1'b0;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.op_a      = 32'h0;
        bus.op_b      = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst busy", {63'h0, bus.busy}, 64'd0);
        chk("rst done", {63'h0, bus.done}, 64'd0);
        chk("rst hi",   {32'h0, bus.hi}, 64'h0);
        chk("rst lo",   {32'h0, bus.lo}, 64'h0);
        chk("rst alu",  {bus.alu_a, bus.alu_b ^ {28'h0, bus.alu_ctrl}}, 64'h0);
        reset_n = 1'b1;
        @(negedge clk);

        run_op("u3x5",     1'b0, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, 1'b0);
        run_op("uFFxFF",   1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("s-3x5",    1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run_op("s8x8",     1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
        run_op("s_lozero", 1'b1, 32'hFFFF_0000, 32'h0001_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        run_op("u_ignore", 1'b0, 32'h0000_0006, 32'h0000_0007, 32'h0000_0000, 32'h0000_002A, 1'b1);

        // Abort mid-operation: hi/lo currently hold 0x2A from the previous op.
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.op_a      = 32'h0000_0009;
        bus.op_b      = 32'h0000_0009;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0;
        end
        chk("abort busy_before", {63'h0, bus.busy}, 64'd1);
        reset_n = 1'b0;
        #1;
        chk("abort busy", {63'h0, bus.busy}, 64'd0);
        chk("abort done", {63'h0, bus.done}, 64'd0);
        chk("abort hi",   {32'h0, bus.hi}, 64'h0);
        chk("abort lo",   {32'h0, bus.lo}, 64'h0);
        chk("abort ctrl", {60'h0, bus.alu_ctrl}, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst idle_busy", {63'h0, bus.busy}, 64'd0);

        run_op("u2x7", 1'b0, 32'h0000_0002, 32'h0000_0007, 32'h0000_0000, 32'h0000_000E, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
